hps_capture_sequencer: RTL
==========================

# hps_capture_sequencer

Frame-capture sequencer between the HPS command PIO and the camera pixel pipeline. It decodes the 10-bit command word the HPS writes to the state PIO, arms the pipeline on frame boundaries and counts captured frames. It stops cleanly at frame ends, guards against stalled sensors with a watchdog, and reports status and an interrupt through its own Avalon-MM slave.

## Interface
- TIMEOUT_CYCLES, 50_000_000: watchdog limit in clk cycles while waiting in ARM or RUN.
- CNT_W, 16: width of the frames_done and error counters.
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- cmd_word  in  10  command from the state PIO; [1:0] opcode (00 stop, 01 single, 10 continuous, 11 clear), [9:2] frame count N.
- sof  in  1  one-cycle start-of-frame pulse from the frame source.
- eof  in  1  one-cycle end-of-frame pulse from the frame source.
- capture_en  out  1  pipeline write enable; high while a frame is being captured.
- frame_go  out  1  one-cycle pulse on the cycle a frame capture is accepted.
- irq  out  1  level interrupt; high while done_flag or err_flag is set.
- address  in  2  status slave word address.
- chipselect  in  1  status slave select.
- read  in  1  status slave read strobe.
- write_n  in  1  status slave write strobe, active-low.
- writedata  in  32  status slave write data.
- readdata  out  32  status slave read data; registered, 1-cycle read latency.

## Operation
- Command detection: cmd_word is registered every cycle. A command fires on the cycle after the registered value differs from the previous registered value. An unchanged word issues nothing.
- Frame count: N = cmd_word[9:2]. N = 0 is treated as 1.
- FSM states: IDLE, ARM, RUN, STOPPING, DONE. State encoding for status: 0 to 4 in that order.
- Single command from IDLE or DONE: load remaining = N, clear done_flag, go to ARM.
- Continuous command from IDLE or DONE: set cont = 1, go to ARM.
- Any start command (single or continuous) in ARM, RUN or STOPPING is ignored.
- ARM: on sof, pulse frame_go, raise capture_en, go to RUN.
- RUN: on eof, drop capture_en after the eof cycle and increment frames_done. Then:
  - single: decrement remaining; if it reaches 0, set done_flag and go to DONE, else go to ARM.
  - continuous: go to ARM.
- Stop command: from ARM, go directly to IDLE. From RUN, go to STOPPING; capture_en stays high until eof, then frames_done increments and the FSM goes to IDLE. In IDLE or DONE, stop goes to IDLE. A stop clears cont.
- Clear command: valid only in IDLE or DONE. Zeroes frames_done, err_count, done_flag and err_flag; goes to IDLE. Ignored in other states.
- Watchdog: counts cycles in ARM, RUN and STOPPING and restarts on every state change. On reaching TIMEOUT_CYCLES: set err_flag, increment err_count, drop capture_en, go to IDLE.
- Counters saturate at all-ones.
- Status slave reads:
  - addr 0: {24'b0, err_flag, done_flag, cont, state[2:0], busy, capture_en}. busy is high in ARM, RUN or STOPPING.
  - addr 1: frames_done, zero-extended.
  - addr 2: err_count, zero-extended.
  - addr 3: remaining, zero-extended.
- Status slave write: any write to addr 0 with writedata[0] = 1 clears done_flag and err_flag (W1C). Writes to other addresses are ignored.

## Timing
- Reset values: state IDLE; capture_en 0, frame_go 0, irq 0, readdata 0; all counters and flags 0; remaining 0; cont 0.
- Command latency: cmd_word change at cycle t is registered at t+1; the state changes at t+2.
- sof in ARM at cycle t: frame_go and capture_en are high at t+1.
- eof in RUN at cycle t: capture_en is low at t+1; frames_done is updated at t+1.
- sof and eof in the same cycle:
  - in ARM: treat as sof only.
  - in RUN or STOPPING: treat as eof only; the sof is dropped, so the next frame starts at the following sof.
- Command and eof in the same cycle: the eof is processed first, then the command is evaluated against the resulting state on the next cycle.
- irq updates one cycle after its flag changes.
- Asynchronous reset mid-frame drops capture_en immediately.

## Test plan
- Reset, then single with N = 3, then 4 sof/eof pairs -> exactly 3 frame_go pulses; frames_done = 3; state DONE; irq = 1; 4th frame not captured.
- Continuous, 5 frames, then stop issued mid-frame -> capture_en held until the 6th eof; frames_done = 6; state IDLE; cont = 0.
- TIMEOUT_CYCLES = 100, single N = 1, no sof -> err_flag set at cycle 100 in ARM; err_count = 1; irq = 1; state IDLE.
- sof and eof asserted together while in RUN -> frame ends; no frame_go on that cycle; frames_done + 1.
- W1C write of 1 to addr 0 in DONE -> done_flag = 0, irq = 0. Clear command issued in RUN -> ignored, counters unchanged.
- Single N = 0 -> one frame captured. Command word rewritten with the same value -> no new command issued.

Source files
------------

// File: rtl/hps_capture_sequencer.sv
// rtl/hps_capture_sequencer.sv - frame-capture sequencer with watchdog and Avalon-MM status slave
module hps_capture_sequencer #(
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int CNT_W          = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [9:0]  cmd_word,
   input  logic        sof,
   input  logic        eof,
   output logic        capture_en,
   output logic        frame_go,
   output logic        irq,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        read,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata
);

   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] OP_STOP   = 2'b00;
   localparam logic [1:0] OP_SINGLE = 2'b01;
   localparam logic [1:0] OP_CONT   = 2'b10;
   localparam logic [1:0] OP_CLEAR  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ARM      = 3'd1,
      S_RUN      = 3'd2,
      S_STOPPING = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [9:0]         r_cmd;
   logic [9:0]         r_cmd_prev;
   logic [WD_W-1:0]    r_wdog;
   logic [7:0]         r_remaining;
   logic               r_cont;
   logic               r_done_flag;
   logic               r_err_flag;
   logic [CNT_W-1:0]   r_frames_done;
   logic [CNT_W-1:0]   r_err_count;
   logic               r_capture_en;
   logic               r_frame_go;
   logic               r_irq;
   logic [31:0]        r_readdata;

   logic               w_busy;
   logic               w_cmd_fire;
   logic               w_eof_evt;
   logic               w_cmd_ok;
   logic [1:0]         w_op;
   logic [7:0]         w_n;
   logic               w_wd_hit;
   logic               w_w1c;
   logic               w_load;
   logic               w_set_cont;
   logic               w_clr_cont;
   logic               w_clear;
   logic               w_accept;
   logic               w_count;
   logic               w_dec;
   logic               w_set_done;
   logic               w_timeout;
   logic               w_unused_wdata;

   assign w_busy     = (r_state == S_ARM) || (r_state == S_RUN) || (r_state == S_STOPPING);
   assign w_cmd_fire = (r_cmd != r_cmd_prev);
   assign w_eof_evt  = eof && ((r_state == S_RUN) || (r_state == S_STOPPING));
   // An eof takes the cycle; a coincident command waits one cycle and sees the new state
   assign w_cmd_ok   = w_cmd_fire && !w_eof_evt;
   assign w_op       = r_cmd[1:0];
   assign w_n        = (r_cmd[9:2] == 8'd0) ? 8'd1 : r_cmd[9:2];
   assign w_wd_hit   = w_busy && (r_wdog == WD_LAST);
   assign w_w1c      = chipselect && !write_n && (address == 2'd0) && writedata[0];
   assign w_unused_wdata = ^writedata[31:1];

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next-state and event decode: eof beats command, command beats sof, watchdog last
   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_set_cont = 1'b0;
      w_clr_cont = 1'b0;
      w_clear    = 1'b0;
      w_accept   = 1'b0;
      w_count    = 1'b0;
      w_dec      = 1'b0;
      w_set_done = 1'b0;
      w_timeout  = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_cmd_ok) begin
               case (w_op)
                  OP_STOP:   begin w_next = S_IDLE; w_clr_cont = 1'b1; end
                  OP_SINGLE: begin w_next = S_ARM;  w_load = 1'b1;     end
                  OP_CONT:   begin w_next = S_ARM;  w_set_cont = 1'b1; end
                  default:   begin w_next = S_IDLE; w_clear = 1'b1;    end
               endcase
            end
         end
         S_ARM: begin
            if (w_cmd_ok && (w_op == OP_STOP)) begin
               w_next     = S_IDLE;
               w_clr_cont = 1'b1;
            end else if (sof) begin
               w_next   = S_RUN;
               w_accept = 1'b1;
            end else if (w_wd_hit) begin
               w_next    = S_IDLE;
               w_timeout = 1'b1;
            end
         end
         S_RUN: begin
            if (eof) begin
               w_count = 1'b1;
               if (r_cont) begin
                  w_next = S_ARM;
               end else begin
                  w_dec = 1'b1;
                  if (r_remaining <= 8'd1) begin
                     w_next     = S_DONE;
                     w_set_done = 1'b1;
                  end else begin
                     w_next = S_ARM;
                  end
               end
            end else if (w_cmd_ok && (w_op == OP_STOP)) begin
               w_next     = S_STOPPING;
               w_clr_cont = 1'b1;
            end else if (w_wd_hit) begin
               w_next    = S_IDLE;
               w_timeout = 1'b1;
            end
         end
         S_STOPPING: begin
            if (eof) begin
               w_next  = S_IDLE;
               w_count = 1'b1;
            end else if (w_wd_hit) begin
               w_next    = S_IDLE;
               w_timeout = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Command capture; the previous value is held while a command is deferred behind an eof
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cmd      <= 10'd0;
         r_cmd_prev <= 10'd0;
      end else begin
         r_cmd <= cmd_word;
         if (!(w_cmd_fire && w_eof_evt)) r_cmd_prev <= r_cmd;
      end
   end

   // Watchdog restarts on every state change and idles outside the busy states
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          r_wdog <= '0;
      else if (!w_busy || (w_next != r_state)) r_wdog <= '0;
      else                                   r_wdog <= r_wdog + WD_W'(1);
   end

   // Frame bookkeeping: remaining count, continuous mode, saturating counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_remaining   <= 8'd0;
         r_cont        <= 1'b0;
         r_frames_done <= '0;
         r_err_count   <= '0;
      end else begin
         if (w_load)                                r_remaining <= w_n;
         else if (w_dec && (r_remaining != 8'd0))   r_remaining <= r_remaining - 8'd1;

         if (w_set_cont)                            r_cont <= 1'b1;
         else if (w_clr_cont || w_load)             r_cont <= 1'b0;

         if (w_clear)                               r_frames_done <= '0;
         else if (w_count && (r_frames_done != '1)) r_frames_done <= r_frames_done + CNT_W'(1);

         if (w_clear)                               r_err_count <= '0;
         else if (w_timeout && (r_err_count != '1)) r_err_count <= r_err_count + CNT_W'(1);
      end
   end

   // Sticky flags; a same-cycle set wins over any clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_done_flag <= 1'b0;
         r_err_flag  <= 1'b0;
      end else begin
         if (w_set_done)                       r_done_flag <= 1'b1;
         else if (w_clear || w_load || w_w1c)  r_done_flag <= 1'b0;

         if (w_timeout)                        r_err_flag <= 1'b1;
         else if (w_clear || w_w1c)            r_err_flag <= 1'b0;
      end
   end

   // Registered pipeline outputs and interrupt
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_capture_en <= 1'b0;
         r_frame_go   <= 1'b0;
         r_irq        <= 1'b0;
      end else begin
         r_capture_en <= (w_next == S_RUN) || (w_next == S_STOPPING);
         r_frame_go   <= w_accept;
         r_irq        <= r_done_flag || r_err_flag;
      end
   end

   // Status read port with one cycle of latency
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_readdata <= 32'd0;
      end else if (chipselect && read) begin
         case (address)
            2'd0:    r_readdata <= {24'd0, r_err_flag, r_done_flag, r_cont, r_state, w_busy, r_capture_en};
            2'd1:    r_readdata <= 32'(r_frames_done);
            2'd2:    r_readdata <= 32'(r_err_count);
            default: r_readdata <= 32'(r_remaining);
         endcase
      end
   end

   assign capture_en = r_capture_en;
   assign frame_go   = r_frame_go;
   assign irq        = r_irq;
   assign readdata   = r_readdata;

endmodule
